phy_tx: RTL and testbench
=========================

# phy_tx

Transmit half of the physical layer: accepts one byte on each of four parallel lanes per frame, interleaves them lane 0→3, and serializes each byte MSB-first onto a single line at the `clk_32f` bit rate. After reset it first emits a block of `8'hBC` comma bytes so the receive side can align. During traffic, any lane with `valid` low is sent as `8'hBC`. It sits between the lane-striping logic and the serial link, mirroring `phy_rx`.

## Interface
- `SYNC_FRAMES`, default 1: number of whole 32-bit frames of `8'hBC` sent after reset before lane data; must be ≥1.
- `clk_32f`  in  1  bit clock, single clock domain, rising edge.
- `rst_L`  in  1  reset, asynchronous, active-low.
- `data_in_0`..`data_in_3`  in  8 each  lane bytes, sampled at frame capture.
- `valid_in_0`..`valid_in_3`  in  1 each  lane byte valid, sampled with data.
- `data_out`  out  1  serial bit stream, registered.
- `frame_ack`  out  1  one-cycle pulse: lane inputs were captured on the edge that raised it.
- `idle_out`  out  1  high while sync frames or an all-invalid frame are on the line.

## Operation
- Edge numbering: posedge k is the k-th rising edge after `rst_L` rises, with k = 0 first.
- Posedge k drives `data_out` = bit (7 − k mod 8) of byte slot ⌊k/8⌋.
- Slot s carries lane s mod 4.
- A frame is 4 consecutive slots (32 bits).
- FSM has two states, SYNC and ACTIVE; it resets to SYNC.
- SYNC:
  - Every slot is `8'hBC`.
  - After `SYNC_FRAMES` × 32 bits, go to ACTIVE; the first ACTIVE bit is at posedge 32·`SYNC_FRAMES`.
- Capture:
  - Happens at every posedge k with k mod 32 = 31 and k ≥ 32·`SYNC_FRAMES` − 1.
  - All four `data_in_*` / `valid_in_*` are latched into a 4×8 frame buffer plus 4 valid bits.
  - The same edge sets `frame_ack`=1; it clears on the next edge.
  - The buffer drives the 32 bits of the following frame.
  - Upstream holds the inputs stable until it sees `frame_ack`, and may change them afterward.
- ACTIVE:
  - Slot byte = latched lane byte if its latched valid = 1, otherwise `8'hBC`.
  - A valid byte equal to `8'hBC` is sent unchanged; there is no escaping.
- `idle_out` updates only on capture edges:
  - 1 if all four captured valids are 0, else 0.
  - Forced to 1 throughout SYNC.
- Counters: 3-bit bit counter and 2-bit lane counter, both wrapping naturally. A sync-frame counter saturates once ACTIVE is reached.
- Reset, asynchronous, any time including mid-byte:
  - `data_out`=0, `frame_ack`=0, `idle_out`=1.
  - Counters = 0, frame buffer = 0, valids = 0, state = SYNC.
  - The partial byte is abandoned and sync restarts from slot 0.

## Timing
- Bit period is 1 `clk_32f` cycle; byte period 8 cycles; frame period 32 cycles.
- Latency from capture edge (k = 32n+31) to MSB of lane 0 on `data_out`: 1 cycle (posedge 32n+32).
- Lane j MSB appears at posedge 32n+32+8j.
- `frame_ack` is high for exactly 1 cycle every 32 cycles once the first capture occurs; it is never asserted earlier.
- `idle_out` changes only with `frame_ack`: it reflects the frame being transmitted during the next 32 cycles.
- No back-pressure; the block never stalls.

## Structure
- Shared package `phy_pkg`:
  - `COM_CHAR` = `8'hBC`
  - `NUM_LANES` = 4
  - `LANE_W` = 8
  - FSM state encoding (SYNC, ACTIVE)
- Natural sub-module: `piso8`, an 8-bit parallel-in/serial-out MSB-first shifter with load strobe. It is reusable for any byte lane.
- Top `phy_tx` holds the FSM, counters, frame buffer, lane mux and comma substitution.

## Test plan
- Reset release, all valids 0 → first 32 bits are 10111100 ×4, `idle_out`=1 throughout, `frame_ack` first high after posedge 31.
- Lanes F2/15/DD/45, all valid, held until ack → posedges 32–63 emit 11110010 00010101 11011101 01000101; `idle_out`=0 from posedge 31.
- Same frame with `valid_in_1`=0 → slot 1 emits 10111100; other lanes unchanged; `idle_out`=0.
- Inputs changed mid-frame (not at ack) from AA to 13 on lane 2 → the current frame still sends the previously captured byte; 13 appears only in the next frame.
- Valid lane byte BC on lane 0 → 10111100 sent, `idle_out`=0.
- `rst_L` pulsed low at bit 3 of lane 2 → outputs clear immediately; after release, `SYNC_FRAMES`×4 comma bytes are sent again before data. Repeat with `SYNC_FRAMES`=2 to confirm 64 sync bits.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared types and constants for the serial PHY transmit path.
// Comma character, lane geometry and FSM encoding.
package phy_pkg;

    localparam logic [7:0] COM_CHAR  = 8'hBC;
    localparam int         NUM_LANES = 4;
    localparam int         LANE_W    = 8;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/phy_tx_piso8.sv
// 8-bit parallel-in/serial-out shifter, MSB first.
// The serial output is a register, so a load emits the MSB on that edge.
module piso8
    import phy_pkg::*;
(
    input  logic  clk_32f,
    input  logic  rst_L,
    input  logic  load,
    input  lane_t din,
    output logic  sout
);

    logic [LANE_W-2:0] sr;

    always_ff @(posedge clk_32f or negedge rst_L) begin
        if (!rst_L) begin
            sr   <= '0;
            sout <= 1'b0;
        end else if (load) begin
            sout <= din[LANE_W-1];
            sr   <= din[LANE_W-2:0];
        end else begin
            sout <= sr[LANE_W-2];
            sr   <= {sr[LANE_W-3:0], 1'b0};
        end
    end

endmodule

// File: rtl/phy_tx.sv
// PHY transmit: four byte lanes interleaved and serialized MSB-first,
// preceded by comma sync frames after every reset.
module phy_tx
    import phy_pkg::*;
#(
    parameter int SYNC_FRAMES = 1
) (
    input  logic       clk_32f,
    input  logic       rst_L,
    input  logic [7:0] data_in_0,
    input  logic [7:0] data_in_1,
    input  logic [7:0] data_in_2,
    input  logic [7:0] data_in_3,
    input  logic       valid_in_0,
    input  logic       valid_in_1,
    input  logic       valid_in_2,
    input  logic       valid_in_3,
    output logic       data_out,
    output logic       frame_ack,
    output logic       idle_out
);

    localparam int SF_W = (SYNC_FRAMES > 1) ? $clog2(SYNC_FRAMES) : 1;
    localparam logic [SF_W-1:0] SF_LAST = SF_W'(SYNC_FRAMES - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [2:0]             bit_cnt;
    logic [1:0]             lane_cnt;
    logic [SF_W-1:0]        sf_cnt;
    lane_t                  fbuf [NUM_LANES];
    logic [NUM_LANES-1:0]   fvalid;
    logic [NUM_LANES-1:0]   valid_in;
    logic                   frame_end;
    logic                   capture;
    logic                   load;
    lane_t                  slot_byte;

    assign valid_in  = {valid_in_3, valid_in_2, valid_in_1, valid_in_0};
    assign frame_end = (&bit_cnt) & (&lane_cnt);

    always_ff @(posedge clk_32f or negedge rst_L) begin
        if (!rst_L) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            SYNC:   if (frame_end && sf_cnt == SF_LAST) state_nxt = ACTIVE;
            ACTIVE: state_nxt = ACTIVE;
            default: state_nxt = SYNC;
        endcase
    end

    // The last sync edge doubles as the first capture edge.
    always_comb begin
        capture   = frame_end && (state == ACTIVE || sf_cnt == SF_LAST);
        load      = (bit_cnt == 3'd0);
        slot_byte = COM_CHAR;
        if (state == ACTIVE && fvalid[lane_cnt]) begin
            slot_byte = fbuf[lane_cnt];
        end
    end

    always_ff @(posedge clk_32f or negedge rst_L) begin
        if (!rst_L) begin
            bit_cnt  <= '0;
            lane_cnt <= '0;
            sf_cnt   <= '0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (&bit_cnt) begin
                lane_cnt <= lane_cnt + 2'd1;
            end
            if (state == SYNC && frame_end && sf_cnt != SF_LAST) begin
                sf_cnt <= sf_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_32f or negedge rst_L) begin
        if (!rst_L) begin
            for (int i = 0; i < NUM_LANES; i++) fbuf[i] <= '0;
            fvalid    <= '0;
            frame_ack <= 1'b0;
            idle_out  <= 1'b1;
        end else begin
            frame_ack <= capture;
            if (capture) begin
                fbuf[0]  <= data_in_0;
                fbuf[1]  <= data_in_1;
                fbuf[2]  <= data_in_2;
                fbuf[3]  <= data_in_3;
                fvalid   <= valid_in;
                idle_out <= ~|valid_in;
            end else if (state == SYNC) begin
                idle_out <= 1'b1;
            end
        end
    end

    piso8 u_piso (
        .clk_32f (clk_32f),
        .rst_L   (rst_L),
        .load    (load),
        .din     (slot_byte),
        .sout    (data_out)
    );

endmodule

// File: tb/tb_phy_tx.sv
// Self-checking bench for phy_tx with SYNC_FRAMES of 1 and 2 side by side.
// A bit-index reference model predicts data_out, frame_ack and idle_out.
module tb_phy_tx;

    logic       clk_32f = 1'b0;
    logic       rst_L   = 1'b0;
    logic [7:0] din [4];
    logic       vin [4];
    logic [1:0] dout;
    logic [1:0] ack;
    logic [1:0] idle;

    int checks = 0;
    int errors = 0;

    int         mk [2];
    logic [7:0] md [2][4];
    logic       mv [2][4];
    logic       eb [2];
    logic       ea [2];
    logic       ei [2];

    always #5 clk_32f = ~clk_32f;

    phy_tx #(.SYNC_FRAMES(1)) dut1 (
        .clk_32f    (clk_32f),
        .rst_L      (rst_L),
        .data_in_0  (din[0]),
        .data_in_1  (din[1]),
        .data_in_2  (din[2]),
        .data_in_3  (din[3]),
        .valid_in_0 (vin[0]),
        .valid_in_1 (vin[1]),
        .valid_in_2 (vin[2]),
        .valid_in_3 (vin[3]),
        .data_out   (dout[0]),
        .frame_ack  (ack[0]),
        .idle_out   (idle[0])
    );

    phy_tx #(.SYNC_FRAMES(2)) dut2 (
        .clk_32f    (clk_32f),
        .rst_L      (rst_L),
        .data_in_0  (din[0]),
        .data_in_1  (din[1]),
        .data_in_2  (din[2]),
        .data_in_3  (din[3]),
        .valid_in_0 (vin[0]),
        .valid_in_1 (vin[1]),
        .valid_in_2 (vin[2]),
        .valid_in_3 (vin[3]),
        .data_out   (dout[1]),
        .frame_ack  (ack[1]),
        .idle_out   (idle[1])
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mk[i] = 0;
            eb[i] = 1'b0;
            ea[i] = 1'b0;
            ei[i] = 1'b1;
            for (int j = 0; j < 4; j++) begin
                md[i][j] = 8'h00;
                mv[i][j] = 1'b0;
            end
        end
    endtask

    // One clock edge; the model follows the bit-index rules, then settle.
    task automatic step();
        logic [7:0] b;
        int         kk;
        int         sf;
        @(posedge clk_32f);
        if (rst_L) begin
            for (int i = 0; i < 2; i++) begin
                sf = i + 1;
                kk = mk[i];
                if (kk / 32 < sf) b = 8'hBC;
                else if (mv[i][(kk / 8) % 4]) b = md[i][(kk / 8) % 4];
                else b = 8'hBC;
                eb[i] = b[7 - kk % 8];
                ea[i] = (kk % 32 == 31) && (kk >= 32 * sf - 1);
                if (ea[i]) begin
                    for (int j = 0; j < 4; j++) begin
                        md[i][j] = din[j];
                        mv[i][j] = vin[j];
                    end
                    ei[i] = !(vin[0] | vin[1] | vin[2] | vin[3]);
                end else if (kk / 32 < sf) begin
                    ei[i] = 1'b1;
                end
                mk[i] = kk + 1;
            end
        end
        #1;
    endtask

    task automatic set_lanes(input logic [31:0] d, input logic [3:0] v);
        for (int j = 0; j < 4; j++) begin
            din[j] = d[31 - 8 * j -: 8];
            vin[j] = v[j];
        end
    endtask

    task automatic test_reset();
        set_lanes($urandom, 4'b0000);
        rst_L = 1'b0;
        model_reset();
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({dout[i], ack[i], idle[i]} !== 3'b001) begin
                errors++;
                $display("FAIL reset_state dut%0d got %b%b%b want 001",
                         i, dout[i], ack[i], idle[i]);
            end
        end
        rst_L = 1'b1;
        for (int n = 0; n < 40; n++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({dout[i], ack[i], idle[i]} !== {eb[i], ea[i], ei[i]}) begin
                    errors++;
                    $display("FAIL sync_frame dut%0d k=%0d got %b%b%b want %b%b%b",
                             i, mk[i] - 1, dout[i], ack[i], idle[i], eb[i], ea[i], ei[i]);
                end
            end
        end
    endtask

    task automatic test_frame(input string name, input logic [31:0] d,
                              input logic [3:0] v, input int cycles);
        set_lanes(d, v);
        for (int n = 0; n < cycles; n++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({dout[i], ack[i], idle[i]} !== {eb[i], ea[i], ei[i]}) begin
                    errors++;
                    $display("FAIL %s dut%0d k=%0d got %b%b%b want %b%b%b",
                             name, i, mk[i] - 1, dout[i], ack[i], idle[i],
                             eb[i], ea[i], ei[i]);
                end
            end
        end
    endtask

    task automatic test_mid_frame_change();
        set_lanes(32'h01_02_AA_04, 4'b1111);
        for (int n = 0; n < 80; n++) begin
            step();
            if (mk[0] % 32 == 12) din[2] = 8'h13;
            if (mk[0] % 32 == 28) din[2] = 8'hAA;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({dout[i], ack[i], idle[i]} !== {eb[i], ea[i], ei[i]}) begin
                    errors++;
                    $display("FAIL mid_change dut%0d k=%0d got %b%b%b want %b%b%b",
                             i, mk[i] - 1, dout[i], ack[i], idle[i], eb[i], ea[i], ei[i]);
                end
            end
        end
        din[2] = 8'h13;
        test_frame("mid_change_next", 32'h01_02_13_04, 4'b1111, 64);
    endtask

    task automatic test_random();
        for (int n = 0; n < 640; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                set_lanes($urandom, 4'($urandom_range(0, 15)));
            end
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({dout[i], ack[i], idle[i]} !== {eb[i], ea[i], ei[i]}) begin
                    errors++;
                    $display("FAIL random dut%0d k=%0d got %b%b%b want %b%b%b",
                             i, mk[i] - 1, dout[i], ack[i], idle[i], eb[i], ea[i], ei[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_byte();
        int guard = 0;
        set_lanes(32'hF2_15_DD_45, 4'b1111);
        while (mk[0] % 32 != 20 && guard < 64) begin
            step();
            guard++;
        end
        checks++;
        if (mk[0] % 32 != 20) begin
            errors++;
            $display("FAIL reset_mid_reach k=%0d want k%%32=20", mk[0]);
        end
        rst_L = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({dout[i], ack[i], idle[i]} !== 3'b001) begin
                errors++;
                $display("FAIL reset_async dut%0d got %b%b%b want 001",
                         i, dout[i], ack[i], idle[i]);
            end
        end
        step();
        step();
        rst_L = 1'b1;
        test_frame("resync", 32'hF2_15_DD_45, 4'b1111, 128);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_frame("all_valid", 32'hF2_15_DD_45, 4'b1111, 96);
        test_frame("lane1_invalid", 32'hF2_15_DD_45, 4'b1101, 64);
        test_frame("all_invalid", 32'h11_22_33_44, 4'b0000, 64);
        test_mid_frame_change();
        test_frame("valid_comma", 32'hBC_00_00_00, 4'b0001, 64);
        test_random();
        test_reset_mid_byte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
